// File: rtl/mips_div.sv
// mips_div: iterative radix-2 restoring divider for DIV/DIVU in Execute.
// Produces one quotient bit per cycle and asks the hazard unit to hold the
// pipeline while it works.
//
// Ports:
//   clk        pipeline clock, rising edge
//   reset      asynchronous, active-high reset
//   start      divide instruction in E (level, held while stalled)
//   signed_div 1 = DIV, 0 = DIVU; sampled with start
//   annul      flush of E; aborts any operation
//   opa, opb   dividend / divisor
//   stall_div  combinational pipeline hold request
//   ready      one-cycle result-valid pulse
//   result     {hi = remainder, lo = quotient}
//
// state   | meaning
// IDLE    | waiting for start
// DIVZERO | divisor was zero, result forced to 0
// ON      | one restoring step per cycle
// DONE    | result valid, ready high, pipeline released
module mips_div #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic                 stall_div,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;

  assign sign_a = signed_div & opa[WIDTH-1];
  assign sign_b = signed_div & opb[WIDTH-1];
  // |0x80..0| stays 0x80..0, which is correct when read as unsigned.
  assign abs_a  = sign_a ? ({WIDTH{1'b0}} - opa) : opa;
  assign abs_b  = sign_b ? ({WIDTH{1'b0}} - opb) : opb;

  // The dividend lives in quo_q and is shifted out MSB first into the
  // partial remainder while quotient bits are shifted in at the bottom.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  // On a negative difference shifted < divisor, so it fits in WIDTH bits.
  assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign quo_fix  = negq_q ? ({WIDTH{1'b0}} - quo_step) : quo_step;
  assign rem_fix  = negr_q ? ({WIDTH{1'b0}} - rem_step) : rem_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    result_d  = result_q;
    stall_div = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          stall_div = 1'b1;
          rem_d     = '0;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          negq_d    = sign_a ^ sign_b;
          negr_d    = sign_a;
          cnt_d     = '0;
          state_d   = (opb == '0) ? DIVZERO : ON;
        end
      end
      DIVZERO: begin
        stall_div = 1'b1;
        result_d  = '0;
        state_d   = DONE;
      end
      ON: begin
        stall_div = 1'b1;
        rem_d     = rem_step;
        quo_d     = quo_step;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = {rem_fix, quo_fix};
          state_d  = DONE;
        end
      end
      DONE: begin
        // start is still high for the instruction leaving E; ignore it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush wins over everything: drop the stall now, keep the old result.
    if (annul) begin
      state_d   = IDLE;
      stall_div = 1'b0;
      result_d  = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // A flushed instruction in DONE must not write HI/LO.
  assign ready  = (state_q == DONE) && !annul;
  assign result = result_q;

endmodule

// File: doc/mips_div.md
Name: mips_div

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU in the Execute stage.
- Consumes operands and ALU control decoded out of the D/E pipeline register.
- Drives a stall request back to the hazard unit, which holds stallE and the earlier stages until the quotient and remainder are ready.
- The result is written to HI/LO by the existing hilowrite path.

Parameters:
- WIDTH, 32, operand width. The 64-bit result is {remainder, quotient}.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  a divide instruction is in E. Level signal, held while stalled.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU. Sampled with start.
- annul  input  1  exception or eret flush of E. Abort any operation.
- opa  input  WIDTH  dividend (srcaE after forwarding).
- opb  input  WIDTH  divisor (writedataE after forwarding).
- stall_div  output  1  hold the pipeline. Combinational.
- ready  output  1  result valid pulse, one cycle.
- result  output  2*WIDTH  {hi = remainder, lo = quotient}.

Behaviour:
- Reset (async):
  - state = IDLE, counter = 0, result = 0, ready = 0.
  - stall_div follows from state and inputs.
- States: IDLE, DIVZERO, ON, DONE.
- IDLE:
  - On start & ~annul, latch |opa| and |opb|, the sign flags (signed_div & msb) and the zero-divisor flag.
  - If opb == 0, go to DIVZERO. Otherwise go to ON with counter = 0.
- ON:
  - One restoring step per cycle. Shift the remainder/dividend pair left by 1, then trial-subtract the divisor using a (WIDTH+1)-bit subtract.
  - If the difference is non-negative, keep it and set quotient bit = 1. Otherwise restore and set quotient bit = 0.
  - counter increments each cycle. After WIDTH steps (counter == WIDTH-1), go to DONE.
- DIVZERO: go to DONE after one cycle. The result is defined as 0 for both hi and lo.
- DONE:
  - ready = 1 for exactly this cycle. result is registered on entry and is valid in this cycle.
  - Go to IDLE next cycle.
  - start is ignored in DONE, so the instruction still leaving E cannot retrigger.
- Sign fix (signed_div only):
  - Quotient is negated if sign(opa) XOR sign(opb).
  - Remainder is negated if sign(opa).
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (wraps, no trap).
- stall_div = (state == IDLE & start & ~annul) | state == ON | state == DIVZERO. It is 0 in DONE, so the pipeline advances in the same cycle ready is high.
- Latency:
  - Start seen in cycle 0. ON occupies cycles 1..WIDTH. ready in cycle WIDTH+1 (33 for the default width).
  - Divide by zero: ready in cycle 2.
- annul:
  - Takes priority in any state. Go to IDLE next cycle.
  - ready stays 0 and result keeps its previous value.
  - stall_div drops combinationally in the annul cycle.
- result holds its last completed value until the next completion. The HI/LO write is qualified by ready.
- Back-to-back divides: a second start arriving the cycle after DONE (state is IDLE) begins normally.
- Reset mid-operation: immediate return to IDLE and result = 0. No ready is asserted.

Test Plan:
1. DIVU with opa=100, opb=7, start held -> stall_div=1 for cycles 0..32, ready=1 in cycle 33 only, result hi=2, lo=14.
2. DIV with opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also opa=7, opb=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
3. DIV with opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU with the same operands -> lo=0, hi=0x80000000.
4. Divide by zero, opa=0x1234, opb=0 -> ready in cycle 2, result=0, stall_div high for cycles 0..1 only.
5. annul asserted in cycle 10 of a divide -> stall_div=0 in that cycle, state IDLE in cycle 11, no ready pulse, result unchanged. A following DIVU 9/3 then completes with lo=3, hi=0.
6. reset pulsed mid-divide (cycle 5, not clock-aligned) -> ready=0, result=0 immediately, stall_div=0 with start low. Two back-to-back DIVUs (50/5, then 8/3) -> lo=10, hi=0 in cycle 33, then lo=2, hi=2 in cycle 67.
